// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, condition codes
// and the condition evaluator used by the execute stage.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    localparam logic [3:0] C_ALW    = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0] RNONE    = 4'hF;

    // CC is {ZF, SF, OF}; the reset value has ZF set.
    localparam logic [2:0] CC_RESET = 3'b100;

    // Evaluate a jXX/cmovXX condition against a {ZF, SF, OF} triple.
    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf;
        logic sf;
        logic of;
        logic res;
        zf = cc[2];
        sf = cc[1];
        of = cc[0];
        case (ifun)
            C_ALW:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~(sf ^ of);
            C_G:     res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_execute_stage_if.sv
// D/E inputs, pipeline-control inputs and E/M outputs of the execute stage.
interface alu_execute_stage_if;

    logic        e_valid;
    logic [3:0]  e_icode;
    logic [3:0]  e_ifun;
    logic [63:0] e_valA;
    logic [63:0] e_valB;
    logic [63:0] e_valC;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic        set_cc_en;
    logic        m_stall;
    logic        m_bubble;
    logic        m_valid;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_valE;
    logic [63:0] m_valA;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;
    logic [2:0]  cc;

    modport master (
        output e_valid, e_icode, e_ifun, e_valA, e_valB, e_valC, e_dstE, e_dstM,
        output set_cc_en, m_stall, m_bubble,
        input  m_valid, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM, cc
    );

    modport slave (
        input  e_valid, e_icode, e_ifun, e_valA, e_valB, e_valC, e_dstE, e_dstM,
        input  set_cc_en, m_stall, m_bubble,
        output m_valid, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM, cc
    );

endinterface

// File: rtl/alu_64bit.sv
// Combinational 64-bit ALU computing B op A with {ZF, SF, OF} flags.
// Unknown function codes produce a zero result with OF clear.
module alu_64bit
    import y86_pkg::*;
(
    input  logic [63:0] alu_a,
    input  logic [63:0] alu_b,
    input  logic [3:0]  alu_fun,
    output logic [63:0] result,
    output logic [2:0]  flags
);

    logic [63:0] sum_s;
    logic [63:0] diff_s;
    logic [63:0] and_s;
    logic [63:0] xor_s;
    logic        add_of_s;
    logic        sub_of_s;
    logic        of_s;

    assign sum_s    = alu_b + alu_a;
    assign diff_s   = alu_b - alu_a;
    assign and_s    = alu_b & alu_a;
    assign xor_s    = alu_b ^ alu_a;
    assign add_of_s = (alu_a[63] == alu_b[63]) & (sum_s[63] != alu_b[63]);
    assign sub_of_s = (alu_a[63] != alu_b[63]) & (diff_s[63] != alu_b[63]);

    // Select the unit output and its overflow flag for the requested function.
    always_comb begin
        result = 64'd0;
        of_s   = 1'b0;
        case (alu_fun)
            ALU_ADD: begin result = sum_s;  of_s = add_of_s; end
            ALU_SUB: begin result = diff_s; of_s = sub_of_s; end
            ALU_AND: begin result = and_s;  of_s = 1'b0;     end
            ALU_XOR: begin result = xor_s;  of_s = 1'b0;     end
            default: begin result = 64'd0;  of_s = 1'b0;     end
        endcase
    end

    assign flags = {(result == 64'd0), result[63], of_s};

endmodule

// File: rtl/alu_execute_stage.sv
// Y86-64 execute stage: operand selection, ALU, condition-code register,
// condition evaluation and the E/M pipeline register.
module alu_execute_stage
    import y86_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    alu_execute_stage_if.slave bus
);

    logic [63:0] alu_a_s;
    logic [63:0] alu_b_s;
    logic [3:0]  alu_fun_s;
    logic [63:0] alu_res_s;
    logic [2:0]  alu_flags_s;
    logic        cc_upd_s;
    logic        cnd_s;
    logic [3:0]  dste_s;
    logic        load_bubble_s;

    logic [2:0]  cc_r;
    logic        m_valid_r;
    logic [3:0]  m_icode_r;
    logic        m_cnd_r;
    logic [63:0] m_vale_r;
    logic [63:0] m_vala_r;
    logic [3:0]  m_dste_r;
    logic [3:0]  m_dstm_r;

    // Pick ALU operands A and B from the instruction class.
    always_comb begin
        alu_a_s = 64'd0;
        alu_b_s = 64'd0;
        case (bus.e_icode)
            I_OPQ:             begin alu_a_s = bus.e_valA;             alu_b_s = bus.e_valB; end
            I_RRMOVQ:          begin alu_a_s = bus.e_valA;             alu_b_s = 64'd0;      end
            I_IRMOVQ:          begin alu_a_s = bus.e_valC;             alu_b_s = 64'd0;      end
            I_RMMOVQ, I_MRMOVQ: begin alu_a_s = bus.e_valC;            alu_b_s = bus.e_valB; end
            I_CALL, I_PUSHQ:   begin alu_a_s = 64'hFFFF_FFFF_FFFF_FFF8; alu_b_s = bus.e_valB; end
            I_RET, I_POPQ:     begin alu_a_s = 64'd8;                  alu_b_s = bus.e_valB; end
            default:           begin alu_a_s = 64'd0;                  alu_b_s = 64'd0;      end
        endcase
    end

    assign alu_fun_s = (bus.e_icode == I_OPQ) ? bus.e_ifun : ALU_ADD;

    alu_64bit u_alu (
        .alu_a   (alu_a_s),
        .alu_b   (alu_b_s),
        .alu_fun (alu_fun_s),
        .result  (alu_res_s),
        .flags   (alu_flags_s)
    );

    // Evaluate the branch/cmov condition against the CC value before this edge.
    always_comb begin
        cnd_s = 1'b0;
        if ((bus.e_icode == I_JXX) || (bus.e_icode == I_RRMOVQ)) begin
            cnd_s = cond_eval(bus.e_ifun, cc_r);
        end else begin
            cnd_s = 1'b0;
        end
    end

    // A failed conditional move cancels its register write.
    always_comb begin
        dste_s = bus.e_dstE;
        if ((bus.e_icode == I_RRMOVQ) && !cnd_s) begin
            dste_s = RNONE;
        end else begin
            dste_s = bus.e_dstE;
        end
    end

    assign cc_upd_s = bus.e_valid && (bus.e_icode == I_OPQ) && (bus.e_ifun <= ALU_XOR) &&
                      bus.set_cc_en && !bus.m_stall;

    assign load_bubble_s = bus.m_bubble || !bus.e_valid;

    // Condition-code register; a bubble on the E/M side does not block it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cc_r <= CC_RESET;
        end else if (cc_upd_s) begin
            cc_r <= alu_flags_s;
        end else begin
            cc_r <= cc_r;
        end
    end

    // E/M pipeline register with reset > stall > bubble > load priority.
    always_ff @(posedge clk) begin
        if (reset || (!bus.m_stall && load_bubble_s)) begin
            m_valid_r <= 1'b0;
            m_icode_r <= I_NOP;
            m_cnd_r   <= 1'b0;
            m_vale_r  <= 64'd0;
            m_vala_r  <= 64'd0;
            m_dste_r  <= RNONE;
            m_dstm_r  <= RNONE;
        end else if (bus.m_stall) begin
            m_valid_r <= m_valid_r;
            m_icode_r <= m_icode_r;
            m_cnd_r   <= m_cnd_r;
            m_vale_r  <= m_vale_r;
            m_vala_r  <= m_vala_r;
            m_dste_r  <= m_dste_r;
            m_dstm_r  <= m_dstm_r;
        end else begin
            m_valid_r <= 1'b1;
            m_icode_r <= bus.e_icode;
            m_cnd_r   <= cnd_s;
            m_vale_r  <= alu_res_s;
            m_vala_r  <= bus.e_valA;
            m_dste_r  <= dste_s;
            m_dstm_r  <= bus.e_dstM;
        end
    end

    assign bus.m_valid = m_valid_r;
    assign bus.m_icode = m_icode_r;
    assign bus.m_cnd   = m_cnd_r;
    assign bus.m_valE  = m_vale_r;
    assign bus.m_valA  = m_vala_r;
    assign bus.m_dstE  = m_dste_r;
    assign bus.m_dstM  = m_dstm_r;
    assign bus.cc      = cc_r;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Self-checking bench for alu_execute_stage: directed vector table, hand-written
// stall/bubble/reset sequences, and randomized traffic against a reference model.
module tb_alu_execute_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_execute_stage_if bus ();

    alu_execute_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state (what E/M and CC should hold)
    logic        md_valid;
    logic [3:0]  md_icode;
    logic        md_cnd;
    logic [63:0] md_vale;
    logic [63:0] md_vala;
    logic [3:0]  md_dste;
    logic [3:0]  md_dstm;
    logic [2:0]  md_cc;

    typedef struct packed {
        logic        v;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] va;
        logic [63:0] vb;
        logic [63:0] vc;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic        ccen;
        logic        bub;
        logic        x_valid;
        logic [3:0]  x_icode;
        logic        x_cnd;
        logic [63:0] x_vale;
        logic [3:0]  x_dste;
        logic [3:0]  x_dstm;
        logic [2:0]  x_cc;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic v, input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                                input logic [3:0] dste, input logic [3:0] dstm,
                                input logic ccen, input logic bub,
                                input logic x_valid, input logic [3:0] x_icode, input logic x_cnd,
                                input logic [63:0] x_vale, input logic [3:0] x_dste,
                                input logic [3:0] x_dstm, input logic [2:0] x_cc);
        vec_t r;
        r.v = v; r.icode = icode; r.ifun = ifun; r.va = va; r.vb = vb; r.vc = vc;
        r.dste = dste; r.dstm = dstm; r.ccen = ccen; r.bub = bub;
        r.x_valid = x_valid; r.x_icode = x_icode; r.x_cnd = x_cnd; r.x_vale = x_vale;
        r.x_dste = x_dste; r.x_dstm = x_dstm; r.x_cc = x_cc;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic valid, input logic [3:0] icode,
                           input logic cnd, input logic [63:0] vale, input logic [63:0] vala,
                           input logic [3:0] dste, input logic [3:0] dstm, input logic [2:0] cc);
        check({tag, "_valid"}, {63'd0, bus.m_valid}, {63'd0, valid});
        check({tag, "_icode"}, {60'd0, bus.m_icode}, {60'd0, icode});
        check({tag, "_cnd"},   {63'd0, bus.m_cnd},   {63'd0, cnd});
        check({tag, "_valE"},  bus.m_valE, vale);
        check({tag, "_valA"},  bus.m_valA, vala);
        check({tag, "_dstE"},  {60'd0, bus.m_dstE},  {60'd0, dste});
        check({tag, "_dstM"},  {60'd0, bus.m_dstM},  {60'd0, dstm});
        check({tag, "_cc"},    {61'd0, bus.cc},      {61'd0, cc});
    endtask

    task automatic drive(input logic v, input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                         input logic [3:0] dste, input logic [3:0] dstm,
                         input logic ccen, input logic stall, input logic bub);
        bus.e_valid   = v;
        bus.e_icode   = icode;
        bus.e_ifun    = ifun;
        bus.e_valA    = va;
        bus.e_valB    = vb;
        bus.e_valC    = vc;
        bus.e_dstE    = dste;
        bus.e_dstM    = dstm;
        bus.set_cc_en = ccen;
        bus.m_stall   = stall;
        bus.m_bubble  = bub;
    endtask

    // Spec-level model: signed-exact arithmetic for overflow, flag-based conditions.
    task automatic model_step();
        logic [63:0]        a;
        logic [63:0]        b;
        logic [63:0]        res;
        logic [65:0]        exact;
        logic               zf;
        logic               sf;
        logic               of;
        logic               cnd;
        logic [3:0]         fun;
        if (reset) begin
            md_valid = 1'b0; md_icode = 4'h1; md_cnd = 1'b0; md_vale = 64'd0;
            md_vala = 64'd0; md_dste = 4'hF; md_dstm = 4'hF; md_cc = 3'b100;
            return;
        end
        if (bus.m_stall) return;
        a = 64'd0;
        b = 64'd0;
        case (bus.e_icode)
            4'h6:       begin a = bus.e_valA; b = bus.e_valB; end
            4'h2:       a = bus.e_valA;
            4'h3:       a = bus.e_valC;
            4'h4, 4'h5: begin a = bus.e_valC; b = bus.e_valB; end
            4'h8, 4'hA: begin a = 64'd0 - 64'd8; b = bus.e_valB; end
            4'h9, 4'hB: begin a = 64'd8; b = bus.e_valB; end
            default:    ;
        endcase
        fun = (bus.e_icode == 4'h6) ? bus.e_ifun : 4'h0;
        of = 1'b0;
        case (fun)
            4'h0: begin
                exact = {{2{b[63]}}, b} + {{2{a[63]}}, a};
                res = exact[63:0];
                of = (exact != {{2{res[63]}}, res});
            end
            4'h1: begin
                exact = {{2{b[63]}}, b} - {{2{a[63]}}, a};
                res = exact[63:0];
                of = (exact != {{2{res[63]}}, res});
            end
            4'h2:    res = b & a;
            4'h3:    res = b ^ a;
            default: res = 64'd0;
        endcase
        zf = (res == 64'd0);
        sf = res[63];
        cnd = 1'b0;
        if (bus.e_icode == 4'h7 || bus.e_icode == 4'h2) begin
            case (bus.e_ifun)
                4'h0:    cnd = 1'b1;
                4'h1:    cnd = (md_cc[1] != md_cc[0]) || md_cc[2];
                4'h2:    cnd = (md_cc[1] != md_cc[0]);
                4'h3:    cnd = md_cc[2];
                4'h4:    cnd = !md_cc[2];
                4'h5:    cnd = (md_cc[1] == md_cc[0]);
                4'h6:    cnd = (md_cc[1] == md_cc[0]) && !md_cc[2];
                default: cnd = 1'b0;
            endcase
        end
        if (bus.e_valid && bus.e_icode == 4'h6 && bus.e_ifun < 4'd4 && bus.set_cc_en)
            md_cc = {zf, sf, of};
        if (!bus.e_valid || bus.m_bubble) begin
            md_valid = 1'b0; md_icode = 4'h1; md_cnd = 1'b0; md_vale = 64'd0;
            md_vala = 64'd0; md_dste = 4'hF; md_dstm = 4'hF;
        end else begin
            md_valid = 1'b1;
            md_icode = bus.e_icode;
            md_cnd   = cnd;
            md_vale  = res;
            md_vala  = bus.e_valA;
            md_dste  = (bus.e_icode == 4'h2 && !cnd) ? 4'hF : bus.e_dstE;
            md_dstm  = bus.e_dstM;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] r;
        case ($urandom_range(0, 5))
            0:       r = 64'd0;
            1:       r = 64'h7FFF_FFFF_FFFF_FFFF;
            2:       r = 64'h8000_0000_0000_0000;
            3:       r = {60'd0, 4'($urandom_range(0, 15))};
            default: r = {$urandom, $urandom};
        endcase
        return r;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        drive(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);

        //             v     ic    fn    va                       vb                       vc        dE    dM   cc   bub   xv    xic  xc    xvalE                    xdE   xdM   xcc
        vecs[0]  = mk(1'b1, 4'h6, 4'h3, 64'hD3,                  64'hD3,                  64'd0,    4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 64'd0,                  4'h3, 4'hF, 3'b100);
        vecs[1]  = mk(1'b1, 4'h7, 4'h3, 64'd0,                   64'd0,                   64'h40,   4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'h7, 1'b1, 64'd0,                  4'hF, 4'hF, 3'b100);
        vecs[2]  = mk(1'b1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0,    4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'h3, 4'hF, 3'b011);
        vecs[3]  = mk(1'b1, 4'h2, 4'h2, 64'h55,                  64'd0,                   64'd0,    4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 64'h55,                 4'hF, 4'hF, 3'b011);
        vecs[4]  = mk(1'b1, 4'h6, 4'h1, 64'd7,                   64'd5,                   64'd0,    4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'h3, 4'hF, 3'b010);
        vecs[5]  = mk(1'b1, 4'h6, 4'h1, 64'd7,                   64'd7,                   64'd0,    4'h3, 4'hF, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 64'd0,                  4'h3, 4'hF, 3'b010);
        vecs[6]  = mk(1'b1, 4'h2, 4'h2, 64'h77,                  64'd0,                   64'd0,    4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 4'h2, 1'b1, 64'h77,                 4'h3, 4'hF, 3'b010);
        vecs[7]  = mk(1'b1, 4'hA, 4'h0, 64'h9,                   64'h100,                 64'd0,    4'h4, 4'hF, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 64'hF8,                 4'h4, 4'hF, 3'b010);
        vecs[8]  = mk(1'b1, 4'hB, 4'h0, 64'h100,                 64'h100,                 64'd0,    4'h4, 4'h6, 1'b1, 1'b0, 1'b1, 4'hB, 1'b0, 64'h108,                4'h4, 4'h6, 3'b010);
        vecs[9]  = mk(1'b1, 4'h5, 4'h0, 64'd0,                   64'h20,                  64'h10,   4'hF, 4'h5, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 64'h30,                 4'hF, 4'h5, 3'b010);
        vecs[10] = mk(1'b1, 4'h6, 4'h5, 64'd1,                   64'd1,                   64'd0,    4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 64'd0,                  4'h3, 4'hF, 3'b010);
        vecs[11] = mk(1'b1, 4'h6, 4'h2, 64'd0,                   64'd0,                   64'd0,    4'h3, 4'hF, 1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 64'd0,                  4'hF, 4'hF, 3'b100);
        vecs[12] = mk(1'b0, 4'h6, 4'h3, 64'd1,                   64'd0,                   64'd0,    4'h3, 4'hF, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 64'd0,                  4'hF, 4'hF, 3'b100);
        vecs[13] = mk(1'b1, 4'h7, 4'h4, 64'd0,                   64'd0,                   64'h80,   4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 64'd0,                  4'hF, 4'hF, 3'b100);
        vecs[14] = mk(1'b1, 4'h7, 4'h1, 64'd0,                   64'd0,                   64'h80,   4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'h7, 1'b1, 64'd0,                  4'hF, 4'hF, 3'b100);
        vecs[15] = mk(1'b1, 4'h0, 4'h0, 64'h12,                  64'h34,                  64'h56,   4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 64'd0,                  4'hF, 4'hF, 3'b100);

        // Reset state
        tick();
        tick();
        chk_all("reset", 1'b0, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 3'b100);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].icode, vecs[i].ifun, vecs[i].va, vecs[i].vb, vecs[i].vc,
                  vecs[i].dste, vecs[i].dstm, vecs[i].ccen, 1'b0, vecs[i].bub);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].x_valid, vecs[i].x_icode, vecs[i].x_cnd,
                    vecs[i].x_vale, (vecs[i].x_valid ? vecs[i].va : 64'd0),
                    vecs[i].x_dste, vecs[i].x_dstm, vecs[i].x_cc);
        end

        // Stall holds E/M and CC for three cycles, then stall+bubble, then release
        drive(1'b1, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("pre_stall", 1'b1, 4'h6, 1'b0, 64'd2, 64'd1, 4'h2, 4'hF, 3'b000);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 4'h5, 4'hF, 1'b1, 1'b1, (i == 3));
            tick();
            chk_all($sformatf("stall%0d", i), 1'b1, 4'h6, 1'b0, 64'd2, 64'd1, 4'h2, 4'hF, 3'b000);
        end
        drive(1'b1, 4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 4'h5, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("unstall", 1'b1, 4'h6, 1'b0, 64'd0, 64'd3, 4'h5, 4'hF, 3'b100);

        // Reset mid-stream beats a concurrent stall
        drive(1'b1, 4'h6, 4'h1, 64'd7, 64'd5, 64'd0, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        check("pre_reset_cc", {61'd0, bus.cc}, {61'd0, 3'b010});
        reset = 1'b1;
        drive(1'b1, 4'h6, 4'h3, 64'd9, 64'd1, 64'd0, 4'h3, 4'hF, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("midreset", 1'b0, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 3'b100);
        reset = 1'b0;

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ic;
            logic [3:0] fn;
            ic = 4'($urandom_range(0, 15));
            if (ic == 4'h6 && $urandom_range(0, 4) != 0) fn = 4'($urandom_range(0, 3));
            else fn = 4'($urandom_range(0, 15));
            if (ic != 4'h6 && ic != 4'h2 && ic != 4'h7 && $urandom_range(0, 1) == 0) ic = 4'h6;
            reset = ($urandom_range(0, 59) == 0);
            drive(($urandom_range(0, 9) != 0), ic, fn, rnd64(), rnd64(), rnd64(),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 5) != 0), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 6) == 0));
            tick();
            chk_all($sformatf("rnd%0d", i), md_valid, md_icode, md_cnd, md_vale, md_vala,
                    md_dste, md_dstm, md_cc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
